multicycle_controller: RTL and testbench

Moore-style main control FSM for the multicycle RV32I core variant. It sequences a single shared ALU, a single unified instruction/data memory port and the register file across several cycles per instruction. It sits beside the datapath in the controlpath, fed by the opcode field of the instruction register. It drives every mux select, write enable and memory request.

---
 rtl/multicycle_controller.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences the shared ALU, the unified memory port and the register file.
// Moore outputs, except the FETCH ir_write/pc_update and instr_retired, which also follow mem_ready / next state.
// Memory requests hold until mem_ready; define MULTICYCLE_WAIT_STATES_EN to honour mem_ready (otherwise it reads as 1).
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       instr_retired,
    output logic       illegal_op
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I,
        ALU_WB, BRANCH, JAL, JALR, JALR_LINK, LUI, TRAP
    } state_t;

    state_t state, state_nxt;
    logic   ready;

`ifdef MULTICYCLE_WAIT_STATES_EN
    assign ready = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign ready = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        result_src    = 2'b00;
        instr_retired = 1'b0;
        illegal_op    = 1'b0;

        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = ready;
                pc_update  = ready;
                if (ready) state_nxt = DECODE;
            end
            DECODE: begin
                // Old PC + immediate parked in the ALU-out register as branch target
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = MEM_ADR;
                    OP_ALU_R:          state_nxt = EXEC_R;
                    OP_ALU:            state_nxt = EXEC_I;
                    OP_LUI:            state_nxt = LUI;
                    OP_BRANCH:         state_nxt = BRANCH;
                    OP_JAL:            state_nxt = JAL;
                    OP_JALR:           state_nxt = JALR;
                    default:           state_nxt = TRAP;
                endcase
            end
            MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = (op == OP_LOAD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (ready) state_nxt = MEM_WB;
            end
            MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_nxt  = FETCH;
            end
            MEM_WRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (ready) state_nxt = FETCH;
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_nxt = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_nxt = ALU_WB;
            end
            LUI: begin
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
                state_nxt = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                state_nxt = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_nxt = FETCH;
            end
            JAL: begin
                // Target already in ALU-out; ALU computes link = old PC + 4
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_nxt = ALU_WB;
            end
            JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_nxt  = JALR_LINK;
            end
            JALR_LINK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_nxt = ALU_WB;
            end
            TRAP: begin
                illegal_op = 1'b1;
                state_nxt  = TRAP;
            end
            default: state_nxt = TRAP;
        endcase

        instr_retired = (state_nxt == FETCH) && (state != FETCH) && (state != TRAP);

        // Reset is asynchronous: outputs are quiet for the whole time it is held
        if (rst) begin
            mem_req       = 1'b0;
            mem_write     = 1'b0;
            adr_src       = 1'b0;
            ir_write      = 1'b0;
            pc_update     = 1'b0;
            branch        = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            result_src    = 2'b00;
            instr_retired = 1'b0;
            illegal_op    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control words queued by stimulus,
// popped and compared by an independent monitor on the falling edge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_write, adr_src, ir_write, pc_update, branch, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       instr_retired, illegal_op;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_update(pc_update), .branch(branch),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src),
        .instr_retired(instr_retired), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Field order: req wr adr ir pc br rw ill ret | a b aluop rs
    typedef struct packed {
        logic       req, wr, adr, ir, pc, br, rw, ill, ret;
        logic [1:0] a, b, aop, rs;
    } ctl_t;

    localparam ctl_t C_RST   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00};
    localparam ctl_t C_F     = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10};
    localparam ctl_t C_FW    = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10};
    localparam ctl_t C_D     = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00};
    localparam ctl_t C_MADR  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00};
    localparam ctl_t C_MRD   = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00};
    localparam ctl_t C_MWB   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,2'b00,2'b01};
    localparam ctl_t C_MWR   = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00};
    localparam ctl_t C_EXR   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00};
    localparam ctl_t C_EXI   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b10,2'b00};
    localparam ctl_t C_LUI   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b11,2'b00};
    localparam ctl_t C_AWB   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00};
    localparam ctl_t C_BR    = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b01,2'b00};
    localparam ctl_t C_JAL   = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b00,2'b00};
    localparam ctl_t C_JALR  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b10};
    localparam ctl_t C_JLINK = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b00,2'b00};
    localparam ctl_t C_TRAP  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00};
    // MEM_WRITE still waiting: no retire yet
    localparam ctl_t C_MWRW  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00};

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, ALU_R = 7'b0110011,
                           ALU_I = 7'b0010011, LUI_OP = 7'b0110111, BEQ = 7'b1100011,
                           JAL_OP = 7'b1101111, JALR_OP = 7'b1100111, BAD = 7'b0000000;

    ctl_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passed = 0;
    bit    stim_done = 1'b0;

    // One clock cycle of stimulus: drive inputs just after the edge, queue that cycle's expected outputs
    task automatic step(input logic [6:0] o, input logic rdy, input logic r, input ctl_t e, input string nm);
        @(posedge clk);
        #1;
        op = o;
        mem_ready = rdy;
        rst = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    function automatic ctl_t sample();
        ctl_t s;
        s = '{mem_req, mem_write, adr_src, ir_write, pc_update, branch, reg_write,
              illegal_op, instr_retired, alu_src_a, alu_src_b, alu_op, result_src};
        return s;
    endfunction

    // Monitor: compares whatever the DUT presents against the oldest queued expectation
    initial begin
        ctl_t  got, e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = sample();
                checks++;
                if (got === e) passed++;
                else $display("FAIL %s: got %h expected %h", nm, got, e);
            end
        end
    end

    initial begin
        // Reset held with mem_ready high: everything quiet
        step(ALU_I, 1'b1, 1'b1, C_RST, "reset0");
        step(ALU_I, 1'b1, 1'b1, C_RST, "reset1");

        // addi x1,x0,5 (0x00500093)
        step(ALU_I, 1'b1, 1'b0, C_F,   "addi_fetch");
        step(ALU_I, 1'b1, 1'b0, C_D,   "addi_decode");
        step(ALU_I, 1'b1, 1'b0, C_EXI, "addi_exec");
        step(ALU_I, 1'b1, 1'b0, C_AWB, "addi_wb");

        // lw with two wait cycles in MEM_READ
        step(LOAD, 1'b1, 1'b0, C_F,    "lw_fetch");
        step(LOAD, 1'b1, 1'b0, C_D,    "lw_decode");
        step(LOAD, 1'b1, 1'b0, C_MADR, "lw_adr");
`ifdef MULTICYCLE_WAIT_STATES_EN
        step(LOAD, 1'b0, 1'b0, C_MRD,  "lw_read_wait0");
        step(LOAD, 1'b0, 1'b0, C_MRD,  "lw_read_wait1");
        step(LOAD, 1'b1, 1'b0, C_MRD,  "lw_read_done");
`else
        step(LOAD, 1'b0, 1'b0, C_MRD,  "lw_read_ready_ignored");
`endif
        step(LOAD, 1'b1, 1'b0, C_MWB,  "lw_wb");

        // sw with one wait cycle on fetch and on the write
`ifdef MULTICYCLE_WAIT_STATES_EN
        step(STORE, 1'b0, 1'b0, C_FW,  "sw_fetch_wait");
`endif
        step(STORE, 1'b1, 1'b0, C_F,    "sw_fetch");
        step(STORE, 1'b1, 1'b0, C_D,    "sw_decode");
        step(STORE, 1'b1, 1'b0, C_MADR, "sw_adr");
`ifdef MULTICYCLE_WAIT_STATES_EN
        step(STORE, 1'b0, 1'b0, C_MWRW, "sw_write_wait");
`endif
        step(STORE, 1'b1, 1'b0, C_MWR,  "sw_write");

        // beq
        step(BEQ, 1'b1, 1'b0, C_F,  "beq_fetch");
        step(BEQ, 1'b1, 1'b0, C_D,  "beq_decode");
        step(BEQ, 1'b1, 1'b0, C_BR, "beq_branch");

        // jal
        step(JAL_OP, 1'b1, 1'b0, C_F,   "jal_fetch");
        step(JAL_OP, 1'b1, 1'b0, C_D,   "jal_decode");
        step(JAL_OP, 1'b1, 1'b0, C_JAL, "jal_jump");
        step(JAL_OP, 1'b1, 1'b0, C_AWB, "jal_link_wb");

        // jalr
        step(JALR_OP, 1'b1, 1'b0, C_F,     "jalr_fetch");
        step(JALR_OP, 1'b1, 1'b0, C_D,     "jalr_decode");
        step(JALR_OP, 1'b1, 1'b0, C_JALR,  "jalr_jump");
        step(JALR_OP, 1'b1, 1'b0, C_JLINK, "jalr_link");
        step(JALR_OP, 1'b1, 1'b0, C_AWB,   "jalr_wb");

        // add (R-type) and lui
        step(ALU_R, 1'b1, 1'b0, C_F,    "add_fetch");
        step(ALU_R, 1'b1, 1'b0, C_D,    "add_decode");
        step(ALU_R, 1'b1, 1'b0, C_EXR,  "add_exec");
        step(ALU_R, 1'b1, 1'b0, C_AWB,  "add_wb");
        step(LUI_OP, 1'b1, 1'b0, C_F,   "lui_fetch");
        step(LUI_OP, 1'b1, 1'b0, C_D,   "lui_decode");
        step(LUI_OP, 1'b1, 1'b0, C_LUI, "lui_exec");
        step(LUI_OP, 1'b1, 1'b0, C_AWB, "lui_wb");

        // Reset mid-load: aborted with no retire, restart at FETCH
        step(LOAD, 1'b1, 1'b0, C_F,    "abort_fetch");
        step(LOAD, 1'b1, 1'b0, C_D,    "abort_decode");
        step(LOAD, 1'b1, 1'b1, C_RST,  "abort_reset");
        step(LOAD, 1'b1, 1'b0, C_F,    "abort_refetch");
        step(LOAD, 1'b1, 1'b0, C_D,    "abort_redecode");
        step(LOAD, 1'b1, 1'b0, C_MADR, "abort_readr");
        step(LOAD, 1'b1, 1'b0, C_MRD,  "abort_reread");
        step(LOAD, 1'b1, 1'b0, C_MWB,  "abort_rewb");

        // Illegal opcode: absorbing TRAP, regardless of mem_ready or op
        step(BAD, 1'b1, 1'b0, C_F, "bad_fetch");
        step(BAD, 1'b1, 1'b0, C_D, "bad_decode");
        for (int i = 0; i < 20; i++)
            step((i % 2 == 0) ? BAD : ALU_I, 1'(i % 3 == 0), 1'b0, C_TRAP, $sformatf("trap_hold%0d", i));
        step(BAD, 1'b1, 1'b1, C_RST, "trap_reset");
        step(ALU_I, 1'b1, 1'b0, C_F, "trap_cleared_fetch");
        step(ALU_I, 1'b1, 1'b0, C_D, "trap_cleared_decode");

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        stim_done = 1'b1;
    end

    initial begin
        fork
            wait (stim_done);
            #100000;
        join_any
        disable fork;
        checks++;
        if (stim_done && exp_q.size() == 0) passed++;
        else $display("FAIL drain: pending %0d done %0d required pending 0 done 1", exp_q.size(), stim_done);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
